// File: rtl/bcd_display_mux_pkg.sv
// ---------------------------------------------------------------------------
// bcd_display_mux_pkg
// Shared definitions for the 4-digit multiplexed elevator display.
//   - Active-low segment patterns {g,f,e,d,c,b,a} for all 16 digit codes
//   - Anode-off / segment-off constants
//   - Scan FSM state type
//   - Elevator display code constants (floor, action, doors)
//   - anode_sel(): one-hot active-low anode pattern for a digit index
// ---------------------------------------------------------------------------
package bcd_display_mux_pkg;

   // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b1111111;   // code F renders as blank

   localparam logic [6:0] SEG_OFF   = 7'b1111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;
   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Scan FSM: anodes dark for the first part of a slot, then one digit driven
   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } disp_state_e;

   // Elevator display codes
   localparam logic [3:0] FLOOR_1     = 4'd1;
   localparam logic [3:0] FLOOR_2     = 4'd2;
   localparam logic [3:0] FLOOR_3     = 4'd3;
   localparam logic [3:0] FLOOR_4     = 4'd4;
   localparam logic [3:0] ACT_UP      = 4'd5;
   localparam logic [3:0] ACT_DOWN    = 4'd8;
   localparam logic [3:0] ACT_IDLE    = 4'd0;
   localparam logic [3:0] DOOR_CLOSED = 4'd7;
   localparam logic [3:0] DOOR_OPEN   = 4'd6;

   // Active-low one-hot anode select for digit index 0..3
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_display_mux_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational 4-bit code to 7-segment decoder (active-low outputs).
//   bcd  in  4  digit code 0..F
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low; code F is blank
// ---------------------------------------------------------------------------
module bcd_to_seg7
   import bcd_display_mux_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (bcd)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/bcd_display_mux.sv
// ---------------------------------------------------------------------------
// bcd_display_mux
// Time-multiplexed 4-digit 7-segment display driver with frame-synchronous
// (tear-free) update of the displayed digits.
//   clk          in   1  system clock
//   rst          in   1  synchronous active-high reset
//   bcd1..bcd4   in   4  digit codes (action, doors, splash, floor)
//   dp_in        in   4  decimal-point request per digit, 1 = lit
//   load         in   1  capture bcd1..4/dp_in into the pending set
//   an           out  4  anodes, active-low, an[0] = bcd1 ... an[3] = bcd4
//   seg          out  7  segments {g..a}, active-low
//   dp           out  1  decimal point, active-low
//   frame_done   out  1  one-cycle pulse after each 4-digit scan
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot
//   BLANK_CYCLES cycles at the start of each slot with all anodes off
// ---------------------------------------------------------------------------
module bcd_display_mux
   import bcd_display_mux_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd2,
   input  logic [3:0] bcd3,
   input  logic [3:0] bcd4,
   input  logic [3:0] dp_in,
   input  logic       load,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_done
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   // Scan position
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   disp_state_e      state_q, state_d;

   // Pending (written by load) and active (shown) digit sets
   logic [3:0][3:0]  pend_q, pend_d;
   logic [3:0][3:0]  act_q, act_d;
   logic [3:0]       pend_dp_q, pend_dp_d;
   logic [3:0]       act_dp_q, act_dp_d;

   // Registered pins
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_done_q, frame_done_d;

   logic             slot_end;
   logic             frame_end;
   logic [3:0]       cur_digit;
   logic [6:0]       cur_seg;

   assign slot_end  = (cnt_q == CNT_LAST);
   assign frame_end = slot_end && (idx_q == 2'd3);
   assign cur_digit = act_q[idx_q];

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

   // Slot counter, digit index and FSM next state
   always_comb begin
      cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
      idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
      state_d = state_q;
      case (state_q)
         BLANK:   if (cnt_q == BLANK_LAST) state_d = DRIVE;
         DRIVE:   if (slot_end)            state_d = BLANK;
         default: state_d = BLANK;
      endcase
   end

   // Digit sets: active copies the pre-edge pending value at the frame
   // boundary, so a coincident load only reaches the display a frame later.
   always_comb begin
      pend_d    = pend_q;
      pend_dp_d = pend_dp_q;
      act_d     = act_q;
      act_dp_d  = act_dp_q;
      if (load) begin
         pend_d    = {bcd4, bcd3, bcd2, bcd1};
         pend_dp_d = dp_in;
      end
      if (frame_end) begin
         act_d    = pend_q;
         act_dp_d = pend_dp_q;
      end
   end

   // Pin values from the current FSM state; registered below (1-cycle lag)
   always_comb begin
      an_d         = AN_OFF;
      seg_d        = SEG_OFF;
      dp_d         = 1'b1;
      frame_done_d = frame_end;
      if (state_q == DRIVE) begin
         an_d  = anode_sel(idx_q);
         seg_d = cur_seg;
         dp_d  = ~act_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         state_q      <= BLANK;
         pend_q       <= {4{BCD_BLANK}};
         act_q        <= {4{BCD_BLANK}};
         pend_dp_q    <= '0;
         act_dp_q     <= '0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         state_q      <= state_d;
         pend_q       <= pend_d;
         act_q        <= act_d;
         pend_dp_q    <= pend_dp_d;
         act_dp_q     <= act_dp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot; legal range BLANK_CYCLES+1 to 2^20.
REQ-002 Parameter BLANK_CYCLES, default 8, cycles at the start of each slot with all anodes off; legal range 1 to REFRESH_DIV-1.
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 bcd1, bcd2, bcd3, bcd4  in  4 each  digit codes: bcd1 = action, bcd2 = doors, bcd3 = unused/splash, bcd4 = floor.
REQ-007 dp_in  in  4  decimal-point request per digit, 1 = lit.
REQ-008 load  in  1  capture strobe; sample bcd1..bcd4 and dp_in into the pending set on the same cycle.
REQ-009 an  out  4  anodes, active-low; an[0] shows bcd1 ... an[3] shows bcd4.
REQ-010 seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}.
REQ-011 dp  out  1  decimal point, active-low.
REQ-012 frame_done  out  1  one-cycle pulse at the end of each 4-digit scan.

Function
REQ-013 A slot counter shall count 0..REFRESH_DIV-1 and wrap.
REQ-014 A digit index shall count 0..3, advance when the slot counter wraps, and wrap 3->0.
REQ-015 The FSM shall have two states, BLANK and DRIVE.
REQ-016 BLANK->DRIVE shall occur when the slot count = BLANK_CYCLES-1.
REQ-017 DRIVE->BLANK shall occur when the slot count = REFRESH_DIV-1, with the digit index incrementing on the same cycle.
REQ-018 In BLANK: an = 1111, seg = 1111111, dp = 1.
REQ-019 In DRIVE: an[idx] = 0 and all other anodes = 1; seg = decode(active[idx]); dp = ~active_dp[idx].
REQ-020 an, seg, dp and frame_done shall be registered, so pins lag the internal FSM state by exactly 1 cycle.
REQ-021 Decode table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=1111111 (blank)
REQ-022 load=1 shall overwrite the pending set; any number of loads within a frame shall be allowed, and the last one wins.
REQ-023 Active-set update: at the frame boundary (idx 3 -> 0 wrap), active <= pending and frame_done pulses high for 1 cycle; the display shall never change mid-frame, i.e. no tearing.
REQ-024 load on the same cycle as the frame boundary: the active set takes the old pending value; the new value is displayed from the next frame.
REQ-025 Frame length shall be exactly 4*REFRESH_DIV cycles; anode duty per digit shall be (REFRESH_DIV-BLANK_CYCLES)/(4*REFRESH_DIV).

Reset
REQ-026 On rst=1 at a clk edge, the block shall set:
  - slot counter = 0, idx = 0, state = BLANK
  - pending and active digits = 4'hF, dp sets = 0000
  - an = 1111, seg = 1111111, dp = 1, frame_done = 0
REQ-027 load shall be ignored while rst=1.
REQ-028 Reset mid-slot or mid-frame shall abort the scan; scanning shall restart from digit 0, BLANK, on the first cycle after rst falls.

Structure
REQ-029 A shared package shall hold:
  - the 7-bit segment constants for all 16 codes
  - the anode-off and segment-off constants
  - the FSM state enum (BLANK, DRIVE)
REQ-030 The package shall also hold the elevator display code constants: floor 1-4, action up=5, action down=8, action idle=0, doors closed=7, doors open=6.
REQ-031 The combinational decoder shall be a sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.

Verification
REQ-032 The bench shall use REFRESH_DIV=8 and BLANK_CYCLES=2, giving a frame of 32 cycles.
REQ-033 Reset check: hold rst for 3 cycles -> an=1111, seg=1111111, dp=1, frame_done=0; after release, the first full frame shows every digit blank (seg=1111111 during DRIVE).
REQ-034 Load and display: load with bcd1..4 = 0,7,0,1 during frame 0 -> frame_done pulse at cycle 32; in frame 1 the bench shall see:
  - an=1110 with seg=1000000
  - an=1101 with seg=1111000
  - an=1011 with seg=1000000
  - an=0111 with seg=1111001
REQ-035 Blanking timing: within every slot, an=1111 for exactly 2 cycles, then one anode low for 6 cycles; pins shall lag the FSM by 1 cycle.
REQ-036 No tearing: load bcd4=4 mid-frame while digit 1 is driven -> an[3] still shows the old value this frame and seg=0011001 next frame.
REQ-037 Boundary load: load bcd1=5 on the exact frame-boundary cycle -> the next frame shows the old bcd1; the frame after that shows seg=0010010 on an[0].
REQ-038 Reset mid-frame: assert rst while idx=2 in DRIVE -> outputs off on the next cycle; after release, an[0] is the first anode asserted, after 2 blank cycles.
REQ-039 dp path: dp_in=0100 loaded -> dp=0 only while an=1011 is asserted.
